obi_mem_model_mp: RTL
=====================

Name: obi_mem_model_mp

Overview:
- Parametrised multi-port OBI memory model for core, cache and DMA integration benches; successor to the two-port Harvard model.
- NPORTS OBI slave ports share one word-addressed memory array.
- Round-robin grant (one transaction per cycle), per-port in-order pipelined responses with multiple outstanding transactions, rvalid for both reads and writes, error response for out-of-range addresses, optional pseudo-random grant stalls.

Parameters:
- NPORTS, 2, number of OBI ports (1..8)
- DATA_W, 64, data width in bits (32 or 64)
- ADDR_W, 64, address width in bits
- MEM_BYTES, 1<<20, memory size in bytes (power of two)
- LATENCY, 2, cycles from grant to rvalid (1..15)
- MAX_OUTSTANDING, 4, per-port response queue depth (power of two, >=1)
- STALL_EN, 0, 1 = pseudo-random grant stalls enabled
- STALL_SEED, 16'hACE1, LFSR seed (nonzero)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_i  in  NPORTS  request, one bit per port
- we_i  in  NPORTS  1 = write
- be_i  in  NPORTS*DATA_W/8  byte enables, port p at [p*DATA_W/8 +: DATA_W/8]
- addr_i  in  NPORTS*ADDR_W  byte address, port p at [p*ADDR_W +: ADDR_W]
- wdata_i  in  NPORTS*DATA_W  write data
- gnt_o  out  NPORTS  grant (combinational from req, arbiter state, queue counts, stall bit)
- rvalid_o  out  NPORTS  response valid (registered)
- rdata_o  out  NPORTS*DATA_W  read data (registered; 0 for writes and errors)
- err_o  out  NPORTS  response error (registered)

Behaviour:
- Reset (rst_ni low, asynchronous):
  - gnt_o, rvalid_o, rdata_o, err_o = 0
  - All queues empty; round-robin pointer = port 0; LFSR = STALL_SEED.
  - Memory contents not reset; zero-initialised at time 0 only.
  - Reset mid-operation drops all outstanding responses; writes already granted persist.
- Eligibility: port p eligible when req_i[p]=1 and its queue count < MAX_OUTSTANDING. A response leaving in the same cycle does not free a slot (no bypass).
- Arbitration:
  - At most one gnt_o bit high per cycle.
  - Search starts at rr_ptr, wraps modulo NPORTS; the first eligible port wins.
  - rr_ptr <= winner+1 (mod NPORTS) on a grant; unchanged otherwise.
- Stall:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - If STALL_EN=1 and LFSR[0]=1, no grant that cycle; rr_ptr is held.
- Handshake: a transaction is accepted when req_i[p] & gnt_o[p]. The requester holds req/we/be/addr/wdata stable until granted.
- Address decode:
  - Word index = addr[log2(MEM_BYTES)-1 : log2(DATA_W/8)]; low byte-offset bits ignored.
  - addr >= MEM_BYTES is out of range.
- Execute at grant cycle:
  - Write: bytes with be set update memory at the clock edge ending the grant cycle.
  - Read: samples the memory word at grant. A write granted in cycle t is visible to a read granted in t+1.
  - Out of range: write discarded; read data forced to 0; err flag recorded.
- Queue entry: {rdata, err, countdown=LATENCY-1}, pushed at grant. Every entry's countdown decrements each cycle, saturating at 0.
- Response: when the head countdown is 0, the head pops. The next cycle rvalid_o[p]=1 with rdata_o/err_o from that entry. Net effect: response exactly LATENCY cycles after the grant edge.
- Responses are in order per port, at most one per port per cycle. Different ports respond independently in the same cycle.
- Back-to-back grants to one port give back-to-back rvalid (throughput 1/cycle/port when alone).
- rdata_o/err_o hold their last value when rvalid_o=0.
- Boundaries:
  - Queue full: gnt withheld for that port; the arbiter moves on to other ports.
  - All ports requesting: each granted exactly once per NPORTS grant cycles.
  - NPORTS=1: rr_ptr constant 0.

Test Plan:
- Reset, then port0 write addr 0x100 data 0x1122334455667788 be 0xFF, then read 0x100 -> write rvalid at grant+2 with rdata 0, err 0; read rvalid at grant+2 with rdata 0x1122334455667788.
- Port0 and port1 both hold req for 8 cycles, STALL_EN=0 -> gnt alternates 01,10,01,...; 4 grants each; rvalid per port 2 cycles after each of its grants.
- Port0 issues 6 reads back-to-back without consuming, MAX_OUTSTANDING=4, LATENCY=8 -> gnt high for 4 cycles then low until the first response frees a slot; all 6 responses arrive in order.
- Partial write be=0x0F data 0xAAAAAAAA_BBBBBBBB over word 0xFFFFFFFF_FFFFFFFF, then read -> rdata 0xFFFFFFFF_BBBBBBBB.
- Read at addr MEM_BYTES+8 -> rvalid with err=1, rdata=0; write to the same address -> err=1, and memory word 1 remains unchanged.
- STALL_EN=1, continuous req on port0 for 200 cycles, rst_ni pulsed low mid-run -> gnt rate about 50%, no rvalid without a prior grant; after reset no stale rvalid, and the LFSR sequence restarts from STALL_SEED.

Source files
------------

// File: rtl/obi_mem_model_mp.sv
// Multi-port OBI memory: round-robin grant into one shared word array. Each port's response comes LATENCY cycles after its grant edge, in order.
// Backpressure: gnt is withheld while a port's response queue holds MAX_OUTSTANDING entries or while a pseudo-random stall is active.
module obi_mem_model_mp #(
  parameter int          NPORTS          = 2,
  parameter int          DATA_W          = 64,
  parameter int          ADDR_W          = 64,
  parameter int          MEM_BYTES       = 1 << 20,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          STALL_EN        = 0,
  parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NPORTS-1:0]          req_i,
  input  logic [NPORTS-1:0]          we_i,
  input  logic [NPORTS*DATA_W/8-1:0] be_i,
  input  logic [NPORTS*ADDR_W-1:0]   addr_i,
  input  logic [NPORTS*DATA_W-1:0]   wdata_i,
  output logic [NPORTS-1:0]          gnt_o,
  output logic [NPORTS-1:0]          rvalid_o,
  output logic [NPORTS*DATA_W-1:0]   rdata_o,
  output logic [NPORTS-1:0]          err_o
);

  localparam int BE_W   = DATA_W / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam int IDX_W  = MEM_AW - OFF_W;
  localparam int WORDS  = MEM_BYTES / BE_W;
  localparam int PTR_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int QP_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CD_W   = 4;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CD_W-1:0]  CD_INIT = CD_W'(LATENCY - 1);
  localparam logic [QP_W-1:0]  QP_LAST = QP_W'(MAX_OUTSTANDING - 1);

  logic [DATA_W-1:0] mem_q [WORDS] = '{default: '0};

  logic [PTR_W-1:0]  rr_ptr_q;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_nxt;
  logic              stall;

  logic [DATA_W-1:0] q_dat  [NPORTS][MAX_OUTSTANDING];
  logic              q_err  [NPORTS][MAX_OUTSTANDING];
  logic [CD_W-1:0]   q_cd   [NPORTS][MAX_OUTSTANDING];
  logic [QP_W-1:0]   wptr_q [NPORTS];
  logic [QP_W-1:0]   rptr_q [NPORTS];
  logic [CNT_W-1:0]  cnt_q  [NPORTS];
  logic [NPORTS-1:0] pop;

  logic              win_vld;
  int                win;
  int                cand;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic [IDX_W-1:0]  widx;
  logic              oor;
  logic [DATA_W-1:0] rd_dat;

  // Fibonacci LFSR, taps 16,14,13,11 in right-shift form.
  assign lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign stall    = (STALL_EN != 0) && lfsr_q[0];

  function automatic logic [QP_W-1:0] qinc(input logic [QP_W-1:0] ptr);
    return (ptr == QP_LAST) ? '0 : ptr + 1'b1;
  endfunction

  // Eligibility uses the registered count only: a same-cycle pop never frees a slot.
  always_comb begin
    gnt_o   = '0;
    win_vld = 1'b0;
    win     = 0;
    cand    = 0;
    if (rst_ni && !stall) begin
      for (int i = 0; i < NPORTS; i++) begin
        cand = int'(rr_ptr_q) + i;
        if (cand >= NPORTS) cand = cand - NPORTS;
        if (!win_vld && req_i[cand] && (cnt_q[cand] < MAX_CNT)) begin
          win_vld     = 1'b1;
          win         = cand;
          gnt_o[cand] = 1'b1;
        end
      end
    end
  end

  assign sel_we    = we_i[win];
  assign sel_be    = be_i[win*BE_W +: BE_W];
  assign sel_wdata = wdata_i[win*DATA_W +: DATA_W];
  assign widx      = addr_i[win*ADDR_W + OFF_W +: IDX_W];
  assign oor       = |addr_i[win*ADDR_W + MEM_AW +: ADDR_W - MEM_AW];
  assign rd_dat    = (sel_we || oor) ? '0 : mem_q[widx];

  always_comb begin
    pop = '0;
    for (int p = 0; p < NPORTS; p++)
      pop[p] = (cnt_q[p] != '0) && (q_cd[p][rptr_q[p]] == '0);
  end

  always_ff @(posedge clk_i) begin
    if (win_vld && sel_we && !oor) begin
      for (int b = 0; b < BE_W; b++)
        if (sel_be[b]) mem_q[widx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
    end
  end

  // Payload storage needs no reset; validity lives in the pointers and counts.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (gnt_o[p]) begin
        q_dat[p][wptr_q[p]] <= rd_dat;
        q_err[p][wptr_q[p]] <= oor;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      lfsr_q   <= STALL_SEED;
      rvalid_o <= '0;
      rdata_o  <= '0;
      err_o    <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        wptr_q[p] <= '0;
        rptr_q[p] <= '0;
        cnt_q[p]  <= '0;
        for (int e = 0; e < MAX_OUTSTANDING; e++) q_cd[p][e] <= '0;
      end
    end else begin
      lfsr_q <= lfsr_nxt;
      if (win_vld) rr_ptr_q <= PTR_W'((win + 1) % NPORTS);
      for (int p = 0; p < NPORTS; p++) begin
        rvalid_o[p] <= pop[p];
        if (pop[p]) begin
          rdata_o[p*DATA_W +: DATA_W] <= q_dat[p][rptr_q[p]];
          err_o[p]                    <= q_err[p][rptr_q[p]];
          rptr_q[p]                   <= qinc(rptr_q[p]);
        end
        if (gnt_o[p]) wptr_q[p] <= qinc(wptr_q[p]);
        if (gnt_o[p] && !pop[p])      cnt_q[p] <= cnt_q[p] + 1'b1;
        else if (!gnt_o[p] && pop[p]) cnt_q[p] <= cnt_q[p] - 1'b1;
        for (int e = 0; e < MAX_OUTSTANDING; e++) begin
          if (gnt_o[p] && (wptr_q[p] == QP_W'(e))) q_cd[p][e] <= CD_INIT;
          else if (q_cd[p][e] != '0)               q_cd[p][e] <= q_cd[p][e] - 1'b1;
        end
      end
    end
  end

endmodule
